// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding and counter sizing for the SPI master controller
package spi_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, SCK_HI, SCK_LO, HOLD, GAP} state_t;
  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return $clog2(m);
  endfunction
endpackage

// File: rtl/spi_tx_shifter.sv
// spi_tx_shifter: parallel-load, MSB-first shift register with registered mosi
module spi_tx_shifter #(
  parameter int DATA_LEN = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                shift,
  input  logic                clr,
  input  logic [DATA_LEN-1:0] din,
  output logic                mosi
);
  logic [DATA_LEN-1:0] shreg;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      shreg <= '0;
      mosi  <= 1'b0;
    end else if (load) shreg <= din;
    else if (shift) begin
      mosi  <= shreg[DATA_LEN-1];
      shreg <= {shreg[DATA_LEN-2:0], 1'b0};
    end else if (clr) mosi <= 1'b0;
endmodule

// File: rtl/spi_master_sck_ctrl.sv
// spi_master_sck_ctrl: SPI mode-1 transaction controller driving sck, cs_n, mosi and rx_en
module spi_master_sck_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_LEN = 8,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tx_valid,
  input  logic [DATA_LEN-1:0] tx_data,
  output logic                tx_ready,
  output logic                sck,
  output logic                cs_n,
  output logic                mosi,
  output logic                rx_en,
  output logic                busy,
  output logic                done
);
  localparam int DW = cnt_w(CLK_DIV, CS_SETUP, CS_HOLD);
  localparam int BW = $clog2(DATA_LEN + 1);
  state_t state;
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic dz, last, load, shift, clr;
  assign dz       = div_cnt == '0;
  assign last     = bit_cnt == BW'(DATA_LEN);
  assign load     = state == IDLE && tx_valid;
  assign shift    = dz && (state == SETUP || (state == SCK_LO && !last));
  assign clr      = dz && state == HOLD;
  assign tx_ready = state == IDLE;
  assign busy     = state != IDLE;
  spi_tx_shifter #(.DATA_LEN(DATA_LEN)) u_shift (
    .clk(clk), .rst(rst), .load(load), .shift(shift), .clr(clr), .din(tx_data), .mosi(mosi)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      sck     <= 1'b0;
      cs_n    <= 1'b1;
      rx_en   <= 1'b0;
      done    <= 1'b0;
    end else begin
      if (!dz) div_cnt <= div_cnt - 1'b1;
      case (state)
        IDLE: if (tx_valid) begin
          cs_n    <= 1'b0;
          rx_en   <= 1'b1;
          div_cnt <= DW'(CS_SETUP - 1);
          state   <= SETUP;
        end
        SETUP, SCK_LO: if (dz) begin
          if (shift) begin
            sck     <= 1'b1;
            bit_cnt <= bit_cnt + 1'b1;
            div_cnt <= DW'(CLK_DIV - 1);
            state   <= SCK_HI;
          end else begin
            bit_cnt <= '0;
            div_cnt <= DW'(CS_HOLD - 1);
            state   <= HOLD;
          end
        end
        SCK_HI: if (dz) begin
          sck     <= 1'b0;
          div_cnt <= DW'(CLK_DIV - 1);
          state   <= SCK_LO;
        end
        HOLD: if (dz) begin
          cs_n  <= 1'b1;
          rx_en <= 1'b0;
          done  <= 1'b1;
          state <= GAP;
        end
        GAP: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_spi_master_sck_ctrl.sv
// tb_spi_master_sck_ctrl: directed vectors for the default and a minimum-timing 12-bit controller
module tb_spi_master_sck_ctrl;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;

  logic tx_valid0 = 0;
  logic [7:0] tx_data0 = '0;
  logic tx_ready0, sck0, cs_n0, mosi0, rx_en0, busy0, done0;
  logic tx_valid1 = 0;
  logic [11:0] tx_data1 = '0;
  logic tx_ready1, sck1, cs_n1, mosi1, rx_en1, busy1, done1;

  spi_master_sck_ctrl dut0 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid0), .tx_data(tx_data0), .tx_ready(tx_ready0),
    .sck(sck0), .cs_n(cs_n0), .mosi(mosi0), .rx_en(rx_en0), .busy(busy0), .done(done0)
  );
  spi_master_sck_ctrl #(.DATA_LEN(12), .CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(2)) dut1 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid1), .tx_data(tx_data1), .tx_ready(tx_ready1),
    .sck(sck1), .cs_n(cs_n1), .mosi(mosi1), .rx_en(rx_en1), .busy(busy1), .done(done1)
  );

  int total = 0, bad = 0;

  // Loopback receivers: capture mosi on every observed sck fall, restart at cs_n fall
  logic [7:0] rx0 = '0;
  logic [11:0] rx1 = '0;
  int pul0 = 0, pul1 = 0, unst0 = 0, unst1 = 0;
  logic sck0_q = 0, cs0_q = 1, mosi0_q = 0, sck1_q = 0, cs1_q = 1, mosi1_q = 0;
  always @(negedge clk) begin
    if (cs0_q && !cs_n0) begin
      rx0 <= '0; pul0 <= 0; unst0 <= 0;
    end else if (sck0_q && !sck0) begin
      rx0  <= {rx0[6:0], mosi0};
      pul0 <= pul0 + 1;
      if (mosi0 != mosi0_q) unst0 <= unst0 + 1;
    end
    sck0_q <= sck0; cs0_q <= cs_n0; mosi0_q <= mosi0;
  end
  always @(negedge clk) begin
    if (cs1_q && !cs_n1) begin
      rx1 <= '0; pul1 <= 0; unst1 <= 0;
    end else if (sck1_q && !sck1) begin
      rx1  <= {rx1[10:0], mosi1};
      pul1 <= pul1 + 1;
      if (mosi1 != mosi1_q) unst1 <= unst1 + 1;
    end
    sck1_q <= sck1; cs1_q <= cs_n1; mosi1_q <= mosi1;
  end

  typedef struct {
    logic [11:0] d;
    logic [11:0] exp_rx;
    int          exp_lat;
    int          exp_pul;
  } v_t;
  v_t tv0[4];
  v_t tv1[2];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic wait_done0(input bit keep, output int n);
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (!keep && n == 1) tx_valid0 = 0;
      if (done0) break;
    end
  endtask

  task automatic run0(input v_t v);
    int n;
    @(negedge clk);
    tx_valid0 = 1;
    tx_data0  = v.d[7:0];
    chk("ready_idle", int'(tx_ready0), 1);
    wait_done0(0, n);
    chk("latency", n, v.exp_lat);
    chk("pulses", pul0, v.exp_pul);
    chk("rx_data", int'(rx0), int'(v.exp_rx));
    chk("mosi_stable", unst0, 0);
    @(negedge clk);
  endtask

  initial begin
    int n, g;
    tv0[0] = '{12'h0A5, 12'h0A5, 70, 8};
    tv0[1] = '{12'h000, 12'h000, 70, 8};
    tv0[2] = '{12'h081, 12'h081, 70, 8};
    tv0[3] = '{12'h05A, 12'h05A, 70, 8};
    tv1[0] = '{12'hF0F, 12'hF0F, 52, 12};
    tv1[1] = '{12'h5A3, 12'h5A3, 52, 12};

    #2 rst = 1;
    #1;
    chk("rst_sck", int'(sck0), 0);
    chk("rst_cs_n", int'(cs_n0), 1);
    chk("rst_mosi", int'(mosi0), 0);
    chk("rst_rx_en", int'(rx_en0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_ready", int'(tx_ready0), 1);
    repeat (2) @(negedge clk);
    rst = 0;

    for (int i = 0; i < 4; i++) run0(tv0[i]);

    // Back-to-back with tx_valid held high
    @(negedge clk);
    tx_valid0 = 1;
    tx_data0  = 8'h3C;
    wait_done0(1, n);
    chk("b2b_lat1", n, 70);
    chk("b2b_rx1", int'(rx0), 8'h3C);
    tx_data0 = 8'hFF;
    g = 0;
    while (cs_n0 && g < 10) begin
      g++;
      @(negedge clk);
    end
    chk("b2b_cs_gap", g, 2);
    wait_done0(0, n);
    chk("b2b_lat2", n + 1, 70);
    chk("b2b_rx2", int'(rx0), 8'hFF);
    chk("b2b_pulses2", pul0, 8);
    @(negedge clk);

    // tx_valid pulsed mid-frame must be ignored
    @(negedge clk);
    tx_valid0 = 1;
    tx_data0  = 8'hC3;
    @(negedge clk);
    tx_valid0 = 0;
    repeat (20) @(negedge clk);
    tx_valid0 = 1;
    tx_data0  = 8'h00;
    chk("mid_ready", int'(tx_ready0), 0);
    chk("mid_busy", int'(busy0), 1);
    @(negedge clk);
    tx_valid0 = 0;
    wait_done0(1, n);
    chk("mid_lat", n, 48);
    chk("mid_rx", int'(rx0), 8'hC3);
    chk("gap_ready", int'(tx_ready0), 0);
    @(negedge clk);
    chk("post_gap_ready", int'(tx_ready0), 1);
    @(negedge clk);
    chk("no_new_frame", int'(cs_n0), 1);

    // Async reset during the 4th sck high phase
    tx_valid0 = 1;
    tx_data0  = 8'hE7;
    @(negedge clk);
    tx_valid0 = 0;
    n = 0;
    while (!(pul0 == 3 && sck0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rst4_found", int'(n < 200), 1);
    rst = 1;
    #1;
    chk("rst4_sck", int'(sck0), 0);
    chk("rst4_cs_n", int'(cs_n0), 1);
    chk("rst4_rx_en", int'(rx_en0), 0);
    chk("rst4_mosi", int'(mosi0), 0);
    chk("rst4_ready", int'(tx_ready0), 1);
    @(negedge clk);
    rst = 0;
    run0(tv0[2]);

    // Minimum timing, 12-bit frames
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tx_valid1 = 1;
      tx_data1  = tv1[i].d;
      chk("w12_ready", int'(tx_ready1), 1);
      n = 0;
      while (n < 300) begin
        @(negedge clk);
        n++;
        if (n == 1) tx_valid1 = 0;
        if (done1) break;
      end
      chk("w12_latency", n, tv1[i].exp_lat);
      chk("w12_pulses", pul1, tv1[i].exp_pul);
      chk("w12_rx", int'(rx1), int'(tv1[i].exp_rx));
      chk("w12_stable", unst1, 0);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
